fft_ctrl: RTL
=============

Name: fft_ctrl

Overview:
- Upstream control and streaming front-end for the 16-point radix-2 FFT core: input buffer, twiddle LUT and N=8 parallel butterflies.
- Accepts 16 complex samples over a valid/ready stream and writes them into the core's input buffer in bit-reversed order.
- Sequences the butterfly stages through stage select and write-back pulses, then streams the 16 results out over a second valid/ready port.
- Owns the core's only external control inputs: stage, read_enable, write_enable, write_back and both addresses.

Parameters:
- NPTS, 16, FFT points; power of two; buffer address width AW = log2(NPTS) = 4.
- NUM_STAGES, 4, butterfly stages run per transform (log2(NPTS)).
- STAGE_W, 2, width of core_stage; must satisfy 2^STAGE_W >= NUM_STAGES.
- BF_LAT, 2, butterfly pipeline cycles from stage select to a valid X/Y output.
- BITREV_IN, 1, 1 = bit-reversed load addresses; 0 = natural order.

Ports:
- clk  in  1  clock; rising edge.
- rst_n  in  1  asynchronous reset, active-low.
- start  in  1  begins a transform; sampled in IDLE only.
- busy  out  1  high in every state except IDLE.
- done  out  1  one-cycle pulse on the last output handshake.
- in_valid  in  1  input sample valid.
- in_ready  out  1  high only in LOAD.
- in_data  in  32  sample; [31:16] real, [15:0] imag, Q1.15.
- out_valid  out  1  output sample valid.
- out_ready  in  1  downstream accept.
- out_data  out  32  result sample, same format as in_data.
- out_last  out  1  high with the 16th output sample.
- core_write_enable  out  1  buffer write strobe.
- core_write_address  out  AW  buffer write address.
- core_data_in  out  32  buffer write data.
- core_read_enable  out  1  buffer read enable.
- core_read_address  out  AW  buffer read address.
- core_data_out  in  32  buffer read data; combinational from core_read_address.
- core_write_back  out  1  commits butterfly X/Y results to the buffer.
- core_stage  out  STAGE_W  current stage index for the LUT.

Behaviour:
- Reset (async, rst_n=0): state=IDLE; all counters 0; every output 0; out_data=0.
- Reset mid-operation: abort immediately; buffer contents are don't-care; the next start runs a full transform.
- States: IDLE -> LOAD -> COMPUTE -> UNLOAD -> IDLE.
- IDLE: start=1 -> LOAD with ld_cnt=0. in_valid is ignored in IDLE.
- LOAD:
  - in_ready=1.
  - Each handshake (in_valid&in_ready) does the following in the same cycle: core_write_enable=1, core_data_in=in_data, core_write_address=bitrev(ld_cnt) when BITREV_IN=1, else ld_cnt.
  - ld_cnt increments on each handshake.
  - The handshake at ld_cnt=NPTS-1 moves to COMPUTE with st_cnt=0, wt_cnt=0.
  - in_valid=0 stalls the load; no timeout.
- COMPUTE:
  - in_ready=0; core_stage=st_cnt.
  - wt_cnt increments each cycle. When wt_cnt==BF_LAT: core_write_back=1 for exactly that cycle, wt_cnt is cleared, st_cnt increments.
  - Each stage takes BF_LAT+1 cycles.
  - After the write-back of stage NUM_STAGES-1, move to UNLOAD with rd_cnt=0.
  - COMPUTE total is NUM_STAGES*(BF_LAT+1) = 12 cycles; the transform is not stalled by out_ready.
- UNLOAD:
  - core_read_enable=1, core_read_address=rd_cnt, out_valid=1.
  - out_data=core_data_out (combinational passthrough).
  - out_last=(rd_cnt==NPTS-1).
  - rd_cnt advances only on out_valid&out_ready; out_data stays stable while stalled.
  - The handshake with out_last=1 pulses done for that cycle and moves to IDLE.
- start outside IDLE is ignored.
- core_write_enable and core_write_back are never high in the same cycle.
- Counters wrap modulo NPTS; a wrap only coincides with leaving the state.
- core_stage holds 0 outside COMPUTE.
- core_write_address, core_read_address and core_data_in are 0 while their enables are low.
- Latency from the 16th input handshake to the first out_valid: 12 cycles plus 1 registered state transition, 13 cycles total with default parameters.

Decomposition:
- Package fft_pkg:
  - state enum {IDLE, LOAD, COMPUTE, UNLOAD}.
  - Constants NPTS, AW, NUM_STAGES.
  - A bitrev function of width AW.
  - Sample field offsets REAL_MSB=31, IMAG_MSB=15.
- One sub-module: fft_ctrl_cnt, a parameterised counter with enable, clear and terminal-count flag.
  - Instantiated for ld_cnt/rd_cnt (shared; they are never active together), st_cnt and wt_cnt.

Test Plan:
- Reset: rst_n=0 mid-COMPUTE (st_cnt=2) -> all outputs 0 within the same cycle; then start -> in_ready=1 next cycle.
- Bit-reversed load: in_data=k for k=0..15 with in_valid held high -> write addresses 0,8,4,12,2,10,6,14,1,9,5,13,3,11,7,15 on 16 consecutive cycles.
- Compute sequencing: after load -> core_write_back pulses on cycles 3,6,9,12 of COMPUTE with core_stage=0,1,2,3 respectively; core_write_enable=0 throughout.
- Input stall: in_valid toggling 1,0,1,0 -> only asserted cycles write; ld_cnt reaches 16 after 32 cycles; no duplicate addresses.
- Output backpressure: out_ready low for 5 cycles at rd_cnt=7 -> core_read_address holds 7 and out_data stable; out_last and done occur on the 16th accepted sample; state returns to IDLE.
- End-to-end: impulse input (sample0=0x7FFF0000, rest 0) -> all 16 outputs 0x7FFF0000 ±1 LSB per field after core scaling; a back-to-back start is accepted the cycle after done.

Source files
------------

// File: rtl/fft_pkg.sv
// Shared constants, state encoding, core-control bundle and bit-reverse helper
// for the 16-point radix-2 FFT controller.
package fft_pkg;

  localparam int NPTS       = 16;
  localparam int AW         = $clog2(NPTS);
  localparam int NUM_STAGES = AW;
  localparam int STAGE_W    = 2;
  localparam int SAMPLE_W   = 32;
  localparam int REAL_MSB   = 31;
  localparam int IMAG_MSB   = 15;

  typedef enum logic [1:0] {
    IDLE,
    LOAD,
    COMPUTE,
    UNLOAD
  } state_t;

  // Everything the controller drives into the FFT core, grouped so it can be
  // assembled in one place and fanned out to the ports.
  typedef struct packed {
    logic                we;
    logic [AW-1:0]       waddr;
    logic [SAMPLE_W-1:0] wdata;
    logic                re;
    logic [AW-1:0]       raddr;
    logic                wb;
    logic [STAGE_W-1:0]  stage;
  } core_ctrl_t;

  function automatic logic [AW-1:0] bitrev(input logic [AW-1:0] a);
    logic [AW-1:0] r;
    r = '0;
    for (int i = 0; i < AW; i++) r[i] = a[AW-1-i];
    return r;
  endfunction

endpackage

// File: rtl/fft_ctrl_cnt.sv
// Up-counter with synchronous clear, enable and a terminal-count flag; wraps
// to zero when it advances past MAX.
module fft_ctrl_cnt #(
  parameter int W   = 4,
  parameter int MAX = 15
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic         i_clr,
  input  logic         i_en,
  output logic [W-1:0] o_cnt,
  output logic         o_tc
);

  logic [W-1:0] r_cnt;

  assign o_cnt = r_cnt;
  assign o_tc  = (r_cnt == W'(MAX));

  // NOTE: state registers use non-blocking assignment so every flop samples
  // the pre-edge value of its neighbours.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n)     r_cnt <= '0;
    else if (i_clr) r_cnt <= '0;
    else if (i_en)  r_cnt <= o_tc ? '0 : r_cnt + 1'b1;
  end

endmodule

// File: rtl/fft_ctrl.sv
// Control front-end for the 16-point FFT core: bit-reversed load, stage
// sequencing with write-back pulses, and streamed unload.
module fft_ctrl
  import fft_pkg::*;
#(
  parameter int BF_LAT    = 2,
  parameter int BITREV_IN = 1
) (
  input  logic                clk,
  input  logic                rst_n,
  input  logic                start,
  output logic                busy,
  output logic                done,
  input  logic                in_valid,
  output logic                in_ready,
  input  logic [SAMPLE_W-1:0] in_data,
  output logic                out_valid,
  input  logic                out_ready,
  output logic [SAMPLE_W-1:0] out_data,
  output logic                out_last,
  output logic                core_write_enable,
  output logic [AW-1:0]       core_write_address,
  output logic [SAMPLE_W-1:0] core_data_in,
  output logic                core_read_enable,
  output logic [AW-1:0]       core_read_address,
  input  logic [SAMPLE_W-1:0] core_data_out,
  output logic                core_write_back,
  output logic [STAGE_W-1:0]  core_stage
);

  localparam int WT_W = (BF_LAT < 1) ? 1 : $clog2(BF_LAT + 1);

  state_t             r_state;
  logic               r_busy;
  logic               r_in_ready;
  logic               r_out_valid;

  logic [AW-1:0]      w_idx_cnt;
  logic               w_idx_tc;
  logic [WT_W-1:0]    w_wt_cnt;
  logic               w_wt_tc;
  logic [STAGE_W-1:0] w_st_cnt;
  logic               w_st_tc;

  logic               w_in_hs;
  logic               w_out_hs;
  logic               w_in_compute;
  core_ctrl_t         w_core;

  assign w_in_hs      = in_valid & r_in_ready;
  assign w_out_hs     = r_out_valid & out_ready;
  assign w_in_compute = (r_state == COMPUTE);

  // Load and unload never overlap, so one counter serves as both ld_cnt and rd_cnt.
  fft_ctrl_cnt #(
    .W   (AW),
    .MAX (NPTS - 1)
  ) u_idx_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr ((r_state == IDLE) | w_in_compute),
    .i_en  (w_in_hs | w_out_hs),
    .o_cnt (w_idx_cnt),
    .o_tc  (w_idx_tc)
  );

  fft_ctrl_cnt #(
    .W   (WT_W),
    .MAX (BF_LAT)
  ) u_wt_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (~w_in_compute),
    .i_en  (w_in_compute),
    .o_cnt (w_wt_cnt),
    .o_tc  (w_wt_tc)
  );

  fft_ctrl_cnt #(
    .W   (STAGE_W),
    .MAX (NUM_STAGES - 1)
  ) u_st_cnt (
    .clk   (clk),
    .rst_n (rst_n),
    .i_clr (~w_in_compute),
    .i_en  (w_in_compute & w_wt_tc),
    .o_cnt (w_st_cnt),
    .o_tc  (w_st_tc)
  );

  // Flag outputs are registered alongside the state so they change only on
  // the transition edge.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      r_state     <= IDLE;
      r_busy      <= 1'b0;
      r_in_ready  <= 1'b0;
      r_out_valid <= 1'b0;
    end else begin
      case (r_state)
        IDLE: begin
          if (start) begin
            r_state    <= LOAD;
            r_busy     <= 1'b1;
            r_in_ready <= 1'b1;
          end
        end
        LOAD: begin
          if (w_in_hs && w_idx_tc) begin
            r_state    <= COMPUTE;
            r_in_ready <= 1'b0;
          end
        end
        COMPUTE: begin
          if (w_wt_tc && w_st_tc) begin
            r_state     <= UNLOAD;
            r_out_valid <= 1'b1;
          end
        end
        UNLOAD: begin
          if (w_out_hs && w_idx_tc) begin
            r_state     <= IDLE;
            r_busy      <= 1'b0;
            r_out_valid <= 1'b0;
          end
        end
        default: begin
          r_state     <= IDLE;
          r_busy      <= 1'b0;
          r_in_ready  <= 1'b0;
          r_out_valid <= 1'b0;
        end
      endcase
    end
  end

  always_comb begin
    // NOTE: zero the whole bundle first so no path through the ifs infers a latch.
    w_core = '0;
    if (w_in_hs) begin
      w_core.we    = 1'b1;
      w_core.waddr = (BITREV_IN != 0) ? bitrev(w_idx_cnt) : w_idx_cnt;
      w_core.wdata = in_data;
    end
    if (r_out_valid) begin
      w_core.re    = 1'b1;
      w_core.raddr = w_idx_cnt;
    end
    if (w_in_compute) begin
      w_core.wb    = (w_wt_cnt == WT_W'(BF_LAT));
      w_core.stage = w_st_cnt;
    end
  end

  assign busy               = r_busy;
  assign in_ready           = r_in_ready;
  assign out_valid          = r_out_valid;
  assign out_last           = r_out_valid & w_idx_tc;
  assign done               = w_out_hs & w_idx_tc;
  assign out_data           = r_out_valid ? core_data_out : '0;

  assign core_write_enable  = w_core.we;
  assign core_write_address = w_core.waddr;
  assign core_data_in       = w_core.wdata;
  assign core_read_enable   = w_core.re;
  assign core_read_address  = w_core.raddr;
  assign core_write_back    = w_core.wb;
  assign core_stage         = w_core.stage;

endmodule
